// File: rtl/axil_mem_arbiter.sv
// Two-to-one AXI-Lite arbiter: two requester lanes share one memory manager port, one transaction in flight.
// Optional ARB_FIXED_PRIO_EN: requester 0 always wins; default is round-robin.
module axil_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2*ADDR_WIDTH-1:0] axil_awaddr_sbd,
    input  logic [1:0]              axil_awvalid_sbd,
    output logic [1:0]              axil_awready_sbd,
    input  logic [2*DATA_WIDTH-1:0] axil_wdata_sbd,
    input  logic [1:0]              axil_wvalid_sbd,
    output logic [1:0]              axil_wready_sbd,
    output logic [3:0]              axil_bresp_sbd,
    output logic [1:0]              axil_bvalid_sbd,
    input  logic [1:0]              axil_bready_sbd,
    input  logic [2*ADDR_WIDTH-1:0] axil_araddr_sbd,
    input  logic [1:0]              axil_arvalid_sbd,
    output logic [1:0]              axil_arready_sbd,
    output logic [2*DATA_WIDTH-1:0] axil_rdata_sbd,
    output logic [3:0]              axil_rresp_sbd,
    output logic [1:0]              axil_rvalid_sbd,
    input  logic [1:0]              axil_rready_sbd,
    output logic [ADDR_WIDTH-1:0]   axil_awaddr_mng,
    output logic                    axil_awvalid_mng,
    input  logic                    axil_awready_mng,
    output logic [DATA_WIDTH-1:0]   axil_wdata_mng,
    output logic                    axil_wvalid_mng,
    input  logic                    axil_wready_mng,
    input  logic [1:0]              axil_bresp_mng,
    input  logic                    axil_bvalid_mng,
    output logic                    axil_bready_mng,
    output logic [ADDR_WIDTH-1:0]   axil_araddr_mng,
    output logic                    axil_arvalid_mng,
    input  logic                    axil_arready_mng,
    input  logic [DATA_WIDTH-1:0]   axil_rdata_mng,
    input  logic [1:0]              axil_rresp_mng,
    input  logic                    axil_rvalid_mng,
    output logic                    axil_rready_mng
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

    state_t     state;
    logic       g;
    logic       aw_done, w_done;
    logic [1:0] wr_req, rd_req, any_req;
    logic       sel, sel_wr, grant, aw_hs, w_hs;
`ifndef ARB_FIXED_PRIO_EN
    logic       last;
`endif

    always_comb begin
        wr_req  = axil_awvalid_sbd & axil_wvalid_sbd;
        rd_req  = axil_arvalid_sbd;
        any_req = wr_req | rd_req;
`ifdef ARB_FIXED_PRIO_EN
        sel = !any_req[0];
`else
        sel = any_req[!last] ? !last : last;
`endif
        sel_wr = wr_req[sel];
        // Gated by rst_n so no requester sees a handshake that reset then discards.
        grant  = rst_n && (state == IDLE) && (|any_req);
        aw_hs  = axil_awvalid_mng && axil_awready_mng;
        w_hs   = axil_wvalid_mng && axil_wready_mng;
    end

    assign axil_awready_sbd = (grant && sel_wr)  ? (2'b01 << sel) : 2'b00;
    assign axil_wready_sbd  = (grant && sel_wr)  ? (2'b01 << sel) : 2'b00;
    assign axil_arready_sbd = (grant && !sel_wr) ? (2'b01 << sel) : 2'b00;

    // Return path: data broadcast, handshake only on the granted lane.
    assign axil_rdata_sbd  = {2{axil_rdata_mng}};
    assign axil_rresp_sbd  = {2{axil_rresp_mng}};
    assign axil_bresp_sbd  = {2{axil_bresp_mng}};
    assign axil_rvalid_sbd = (state == RD_DATA && axil_rvalid_mng) ? (2'b01 << g) : 2'b00;
    assign axil_bvalid_sbd = (state == WR_RESP && axil_bvalid_mng) ? (2'b01 << g) : 2'b00;
    assign axil_rready_mng = (state == RD_DATA) && axil_rready_sbd[g];
    assign axil_bready_mng = (state == WR_RESP) && axil_bready_sbd[g];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            g                <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last             <= 1'b1;
`endif
            aw_done          <= 1'b0;
            w_done           <= 1'b0;
            axil_awaddr_mng  <= '0;
            axil_wdata_mng   <= '0;
            axil_araddr_mng  <= '0;
            axil_awvalid_mng <= 1'b0;
            axil_wvalid_mng  <= 1'b0;
            axil_arvalid_mng <= 1'b0;
        end else begin
            case (state)
                IDLE: if (grant) begin
                    g <= sel;
`ifndef ARB_FIXED_PRIO_EN
                    last <= sel;
`endif
                    if (sel_wr) begin
                        axil_awaddr_mng  <= sel ? axil_awaddr_sbd[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                                : axil_awaddr_sbd[ADDR_WIDTH-1:0];
                        axil_wdata_mng   <= sel ? axil_wdata_sbd[2*DATA_WIDTH-1:DATA_WIDTH]
                                                : axil_wdata_sbd[DATA_WIDTH-1:0];
                        aw_done          <= 1'b0;
                        w_done           <= 1'b0;
                        axil_awvalid_mng <= 1'b1;
                        axil_wvalid_mng  <= 1'b1;
                        state            <= WR_REQ;
                    end else begin
                        axil_araddr_mng  <= sel ? axil_araddr_sbd[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                                : axil_araddr_sbd[ADDR_WIDTH-1:0];
                        axil_arvalid_mng <= 1'b1;
                        state            <= RD_ADDR;
                    end
                end
                RD_ADDR: if (axil_arready_mng) begin
                    axil_arvalid_mng <= 1'b0;
                    state            <= RD_DATA;
                end
                RD_DATA: if (axil_rvalid_mng && axil_rready_mng) state <= IDLE;
                WR_REQ: begin
                    if (aw_hs) begin
                        aw_done          <= 1'b1;
                        axil_awvalid_mng <= 1'b0;
                    end
                    if (w_hs) begin
                        w_done          <= 1'b1;
                        axil_wvalid_mng <= 1'b0;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) state <= WR_RESP;
                end
                WR_RESP: if (axil_bvalid_mng && axil_bready_mng) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/axil_mem_arbiter.md
# axil_mem_arbiter

Two-to-one AXI-Lite arbiter that shares the cache's next-level-memory manager port between two requesters (port 0: data cache, port 1: instruction cache). Each requester presents a standard AXI-Lite manager interface to a subordinate-side lane. The arbiter serialises them onto a single AXI-Lite manager port with one outstanding transaction at a time. Arbitration is round-robin between requesters, and a requester's write takes priority over its own read.

## Interface
- ADDR_WIDTH, 32, address width on all AW/AR channels
- DATA_WIDTH, 32, data width on all W/R channels

Lane i of every `_sbd` vector is bits [i*W +: W]. Lane 0 is requester 0.

- clk  in  1  system clock; single clock domain
- rst_n  in  1  synchronous reset, active-low, sampled on rising clk
- axil_awaddr_sbd / axil_awvalid_sbd / axil_awready_sbd  in/in/out  2*ADDR_WIDTH/2/2  write address, per requester
- axil_wdata_sbd / axil_wvalid_sbd / axil_wready_sbd  in/in/out  2*DATA_WIDTH/2/2  write data, per requester
- axil_bresp_sbd / axil_bvalid_sbd / axil_bready_sbd  out/out/in  4/2/2  write response, per requester
- axil_araddr_sbd / axil_arvalid_sbd / axil_arready_sbd  in/in/out  2*ADDR_WIDTH/2/2  read address, per requester
- axil_rdata_sbd / axil_rresp_sbd / axil_rvalid_sbd / axil_rready_sbd  out/out/out/in  2*DATA_WIDTH/4/2/2  read data, per requester
- axil_awaddr_mng / axil_awvalid_mng / axil_awready_mng  out/out/in  ADDR_WIDTH/1/1  write address to memory
- axil_wdata_mng / axil_wvalid_mng / axil_wready_mng  out/out/in  DATA_WIDTH/1/1  write data to memory
- axil_bresp_mng / axil_bvalid_mng / axil_bready_mng  in/in/out  2/1/1  write response from memory
- axil_araddr_mng / axil_arvalid_mng / axil_arready_mng  out/out/in  ADDR_WIDTH/1/1  read address to memory
- axil_rdata_mng / axil_rresp_mng / axil_rvalid_mng / axil_rready_mng  in/in/in/out  DATA_WIDTH/2/1/1  read data from memory

## Operation
**FSM states:** IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. Registers: state, grant index g, last-granted pointer `last`, latched addr/data, aw_done, w_done.

**Candidates in IDLE:**
- Requester i is write-ready when awvalid_sbd[i] && wvalid_sbd[i].
- Requester i is read-ready when arvalid_sbd[i].
- AW valid without W valid (or the reverse) does not request.

**Requester selection (IDLE):**
- Priority goes to requester !last; if it has no candidate, requester `last` is chosen.
- Within the chosen requester: write over read.
- `last` ← g on every grant.

**Grant cycle (IDLE, candidate present):**
- Write: pulse awready_sbd[g] and wready_sbd[g] for 1 cycle; latch awaddr/wdata; clear aw_done/w_done; go to WR_REQ.
- Read: pulse arready_sbd[g] for 1 cycle; latch araddr; go to RD_ADDR.

**RD_ADDR:**
- arvalid_mng=1 with the latched address.
- On arready_mng → RD_DATA.

**RD_DATA:**
- rvalid_sbd[g]=rvalid_mng and rready_mng=rready_sbd[g].
- On rvalid_mng && rready_mng → IDLE.

**WR_REQ:**
- awvalid_mng = !aw_done and wvalid_mng = !w_done; each done flag sets on its own handshake.
- Go to WR_RESP in the cycle both handshakes are complete, including the case where both complete in the same cycle.

**WR_RESP:**
- bvalid_sbd[g]=bvalid_mng and bready_mng=bready_sbd[g].
- On handshake → IDLE.

**Data/response return:**
- rdata_mng, rresp_mng and bresp_mng are broadcast combinationally to both lanes; only lane g sees valid.
- The non-granted lane's valid/ready outputs are 0 at all times.
- Memory-side ready/valid inputs are ignored in states that do not use them.

## Timing
- **Reset values:** state=IDLE, last=1 (so requester 0 wins first), g=0. All `_sbd` and `_mng` valid/ready outputs 0; awaddr/araddr/wdata_mng 0.
- **Reset mid-transaction:** the in-flight transfer is abandoned with no response to the requester. The memory side must be reset together with the arbiter.
- **Read timing:** grant at cycle 0; arvalid_mng from cycle 1. With zero-wait memory (arready at cycle 1, rvalid at cycle 2), rvalid_sbd is high at cycle 2.
- **Write timing:** grant at cycle 0; aw/wvalid_mng from cycle 1; WR_RESP earliest at cycle 2.
- **Back-to-back:** one mandatory IDLE cycle between transactions. The next grant occurs in the cycle after the completing handshake.
- Requesters must hold their valids per AXI until ready. The arbiter never deasserts a `_mng` valid before its handshake.
- **Simultaneous requests:** both requesters requesting in the same IDLE cycle alternate strictly across consecutive grants.

## Configuration
- **ARB_FIXED_PRIO_EN defined:** requester 0 always wins over requester 1. `last` is not used and may be removed. Write-over-read within a requester is unchanged.
- **Undefined (default):** round-robin as described above.

## Test plan
- **Single read:** requester 0 reads 0x0000_1000; memory returns 0xDEAD_BEEF/OKAY one cycle after the AR handshake → rdata_sbd lane 0 = 0xDEAD_BEEF, rvalid_sbd=2'b01 at cycle 2.
- **Contention:** both requesters assert arvalid continuously for 4 transactions → grants ordered 0,1,0,1; the other lane's valid/ready stay 0 throughout.
- **Same-requester priority:** requester 1 asserts write (addr 0x20, data 0x5A5A_5A5A) and read in the same cycle → write granted first; B returns OKAY on lane 1; then the read is granted.
- **Split write handshake:** memory asserts awready at cycle 1 and wready at cycle 4 → awvalid_mng drops after cycle 1, wvalid_mng holds until cycle 4, state enters WR_RESP at cycle 5.
- **Reset mid-read:** rst_n low during RD_DATA → next cycle all valids 0, state IDLE; after release, requester 0 wins the first contended grant.
- **ARB_FIXED_PRIO_EN:** both requesters read continuously → requester 0 granted on every arbitration while it requests.
